writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage: the producing end of the register-file write port.
//  - Captures retiring instructions from the MEM stage.
//  - Waits on data-memory responses for loads.
//  - Selects the result source and drives the one-cycle write port (reg_write/write_reg/write_data).
//  - Sits between the MEM/WB boundary and register_file's write inputs.
// PARAMETERS
//  DATA_W        32  width of results, load data, write_data
//  ADDR_W        5   register index width
//  LOAD_TIMEOUT  15  max cycles in LOAD_WAIT before a load is aborted (>=1)
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       asynchronous active-low reset
//  mem_valid       in   1       MEM stage presents an instruction
//  mem_ready       out  1       WB accepts this cycle; (state==IDLE), combinational
//  mem_reg_write   in   1       instruction writes a register
//  mem_mem_to_reg  in   1       result comes from data memory (load)
//  mem_link        in   1       result is return address (jal/jalr)
//  mem_rd          in   ADDR_W  destination register
//  mem_alu_result  in   DATA_W  ALU result
//  mem_pc_plus4    in   DATA_W  return address
//  dmem_rvalid     in   1       load data valid
//  dmem_rdata      in   DATA_W  load data
//  reg_write       out  1       register-file write enable (registered)
//  write_reg       out  ADDR_W  register-file write index (registered)
//  write_data      out  DATA_W  register-file write data (registered)
//  load_err        out  1       one-cycle pulse: load aborted by timeout
// BEHAVIOUR
//  - Interface: one clock clk; reset rst_n is asynchronous, active-low.
//  - Reset: state=IDLE, reg_write=0, write_reg=0, write_data=0, load_err=0, timeout counter=0.
//    A pending load is dropped with no write. mem_ready=1 immediately after reset release.
//  - Accept: on a clk edge with mem_valid & mem_ready. Capture rd, reg_write, and the source select.
//  - Source priority: mem_link -> mem_pc_plus4; else mem_mem_to_reg -> load; else mem_alu_result.
//  - Write qualifier: we = mem_reg_write & (mem_rd != 0). r0 is never written; the slot is still consumed.
//  - FSM IDLE:
//    - Accept of a non-load (or link) -> load outputs at the same edge.
//      reg_write=we holds for exactly the following cycle; the RF commits at the next edge.
//      Latency: accept edge N, RF updated at edge N+1.
//    - Accept of a load (mem_to_reg & !link) -> go to LOAD_WAIT, clear counter, reg_write=0.
//    - No accept -> reg_write=0 at the next edge (pulse, never held).
//    - Back-to-back non-load accepts give one write per cycle.
//  - FSM LOAD_WAIT (mem_ready=0; mem_valid ignored):
//    - dmem_rvalid=1 -> write_data=dmem_rdata, write_reg=rd, reg_write=we; go to IDLE.
//      A new accept is possible on the cycle after.
//    - Counter reaches LOAD_TIMEOUT without dmem_rvalid -> go to IDLE, no write, load_err=1 for one cycle.
//    - The counter increments each waiting cycle.
//  - dmem_rvalid while in IDLE is ignored. Data on the same edge as the load accept is not captured.
//  - write_reg/write_data hold their last value while reg_write=0.
// CONFIGURATION
//  WB_FWD_EN defined:
//  - Adds outputs fwd_valid(1), fwd_reg(ADDR_W), fwd_data(DATA_W).
//  - These are registered copies of the previous cycle's committed write
//    (valid only if reg_write was 1), so decode can bypass values the RF captured one edge ago.
//  - All fwd_* reset to 0.
//  WB_FWD_EN undefined: fwd_* ports are absent; behaviour is otherwise identical.
// TESTING
//  - ALU path: accept rd=5, alu=0x1234 -> next cycle reg_write=1, write_reg=5, write_data=0x1234;
//    the cycle after that, reg_write=0.
//  - r0 suppression: accept rd=0, reg_write=1, alu=0xFFFF -> reg_write stays 0, mem_ready stays 1.
//  - Load: accept load rd=7; dmem_rvalid after 3 cycles with 0xCAFEBABE -> mem_ready=0 for 4 cycles,
//    then reg_write=1, write_reg=7, write_data=0xCAFEBABE.
//  - Timeout: load rd=9, no dmem_rvalid -> after LOAD_TIMEOUT=15 cycles load_err pulses once,
//    no write, mem_ready=1.
//  - Link priority and back-to-back: link=1, mem_to_reg=1, pc+4=0x40, rd=31, followed by
//    ALU rd=3=0x11 -> consecutive writes (31,0x40) then (3,0x11), with no wait state.
//  - Reset mid-load: assert rst_n=0 in LOAD_WAIT -> outputs 0 asynchronously;
//    a late dmem_rvalid after release causes no write.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage
//   Last pipeline stage and the producing end of the register-file write port.
//   It accepts retiring instructions from MEM and waits for data memory on loads.
//   It selects the result source and drives a registered one-cycle write pulse.
//
//   Handshake: an instruction transfers on a rising clk edge where both
//   mem_valid and mem_ready are 1. mem_ready depends only on the FSM state,
//   so it never depends on mem_valid in the same cycle.
//
//   Optional feature: define WB_FWD_EN to add fwd_valid/fwd_reg/fwd_data. These
//   are registered copies of the write committed on the previous cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_valid/ready   MEM -> WB handshake (ready = state is IDLE)
//   mem_reg_write     instruction writes a register
//   mem_mem_to_reg    result comes from data memory (load)
//   mem_link          result is the return address (has priority over load)
//   mem_rd            destination register
//   mem_alu_result    ALU result
//   mem_pc_plus4      return address
//   dmem_rvalid/rdata load response
//   reg_write         register-file write enable, registered one-cycle pulse
//   write_reg         register-file write index, held while reg_write is 0
//   write_data        register-file write data, held while reg_write is 0
//   load_err          one-cycle pulse when a load times out
//   state_dbg         current FSM state (0 = IDLE, 1 = LOAD_WAIT)
//   fwd_valid/reg/data  (WB_FWD_EN only) previous cycle's committed write
module writeback_stage #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic              mem_link,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              load_err,
`ifdef WB_FWD_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [0:0]        state_dbg
);

  localparam int CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   pend_rd;
  logic                pend_we;
  logic                we;
  logic                is_load;

  // r0 is hard-wired: the instruction is consumed but never writes.
  assign we        = mem_reg_write && (mem_rd != '0);
  // Link takes priority over load, so a linking instruction never waits.
  assign is_load   = mem_mem_to_reg && !mem_link;
  assign mem_ready = (state == IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_rd    <= '0;
      pend_we    <= 1'b0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      load_err   <= 1'b0;
    end else begin
      // Both outputs are pulses. They are cleared by default every cycle.
      reg_write <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            if (is_load) begin
              state   <= LOAD_WAIT;
              cnt     <= '0;
              pend_rd <= mem_rd;
              pend_we <= we;
            end else if (we) begin
              reg_write  <= 1'b1;
              write_reg  <= mem_rd;
              write_data <= mem_link ? mem_pc_plus4 : mem_alu_result;
            end
          end
        end
        LOAD_WAIT: begin
          if (dmem_rvalid) begin
            state <= IDLE;
            if (pend_we) begin
              reg_write  <= 1'b1;
              write_reg  <= pend_rd;
              write_data <= dmem_rdata;
            end
          end else if (32'(cnt) == LOAD_TIMEOUT - 1) begin
            // Last allowed waiting cycle has passed: abandon the load.
            state    <= IDLE;
            load_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid <= 1'b0;
      fwd_reg   <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= reg_write;
      if (reg_write) begin
        fwd_reg  <= write_reg;
        fwd_data <= write_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed instructions; expected writes and load
// errors go into exp_q and a negedge monitor pops one per reported event.
module tb_writeback_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int EW     = 1 + ADDR_W + DATA_W;  // {is_err, rd, data}

  logic              clk;
  logic              rst_n;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_reg_write;
  logic              mem_mem_to_reg;
  logic              mem_link;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_pc_plus4;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              load_err;
  logic [0:0]        state_dbg;
`ifdef WB_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_reg;
  logic [DATA_W-1:0] fwd_data;
`endif

  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int low;

  writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_link(mem_link), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .load_err(load_err),
`ifdef WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] wr_ev(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    return {1'b0, rd, d};
  endfunction

  task automatic drive_instr(input logic rw, input logic m2r, input logic link,
                             input logic [ADDR_W-1:0] rd,
                             input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] pc);
    mem_valid      = 1'b1;
    mem_reg_write  = rw;
    mem_mem_to_reg = m2r;
    mem_link       = link;
    mem_rd         = rd;
    mem_alu_result = alu;
    mem_pc_plus4   = pc;
  endtask

  task automatic idle_inputs();
    mem_valid      = 1'b0;
    mem_reg_write  = 1'b0;
    mem_mem_to_reg = 1'b0;
    mem_link       = 1'b0;
    mem_rd         = '0;
    mem_alu_result = '0;
    mem_pc_plus4   = '0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && (reg_write || load_err)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got we=%0b rd=%0d data=0x%0h err=%0b, required no event",
                 reg_write, write_reg, write_data, load_err);
      end else begin
        logic [EW-1:0] e;
        logic [EW-1:0] g;
        e = exp_q.pop_front();
        g = load_err ? {1'b1, {ADDR_W{1'b0}}, {DATA_W{1'b0}}}
                     : {1'b0, write_reg, write_data};
        if (reg_write && load_err) g = '1;
        check("scoreboard_event", 64'(g), 64'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_reg_write",  64'(reg_write),  64'd0);
    check("reset_write_reg",  64'(write_reg),  64'd0);
    check("reset_write_data", 64'(write_data), 64'd0);
    check("reset_load_err",   64'(load_err),   64'd0);
    check("reset_mem_ready",  64'(mem_ready),  64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(mem_ready), 64'd1);

    // ALU path: rd=5, 0x1234, visible the cycle after accept, then a pulse end.
    exp_q.push_back(wr_ev(5'd5, 32'h1234));
    drive_instr(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0);
    @(negedge clk);
    idle_inputs();
    check("alu_we",   64'(reg_write),  64'd1);
    check("alu_rd",   64'(write_reg),  64'd5);
    check("alu_data", 64'(write_data), 64'h1234);
    @(negedge clk);
    check("alu_pulse_end", 64'(reg_write), 64'd0);
    check("alu_rd_hold",   64'(write_reg), 64'd5);

    // r0 suppression: consumed, no write, still ready.
    drive_instr(1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF, 32'h0);
    @(negedge clk);
    idle_inputs();
    check("r0_we",        64'(reg_write),  64'd0);
    check("r0_ready",     64'(mem_ready),  64'd1);
    check("r0_data_hold", 64'(write_data), 64'h1234);

    // dmem_rvalid while idle is ignored (monitor flags any write).
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("idle_rvalid_ignored", 64'(reg_write), 64'd0);

    // Load rd=7. Data on the accept edge is dropped. mem_valid is ignored while
    // waiting. Data arrives after 3 waiting cycles: ready is low for 4 cycles.
    drive_instr(1'b1, 1'b1, 1'b0, 5'd7, 32'h0, 32'h0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h11112222;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    drive_instr(1'b1, 1'b0, 1'b0, 5'd2, 32'h2222, 32'h0);
    check("load_state_dbg", 64'(state_dbg), 64'd1);
    low = 0;
    for (int i = 0; i < 4; i++) begin
      if (!mem_ready) low++;
      if (i == 3) begin
        idle_inputs();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEBABE;
        exp_q.push_back(wr_ev(5'd7, 32'hCAFEBABE));
      end
      @(negedge clk);
    end
    dmem_rvalid = 1'b0;
    check("load_ready_low_cycles", 64'(low), 64'd4);
    check("load_we",   64'(reg_write),  64'd1);
    check("load_rd",   64'(write_reg),  64'd7);
    check("load_data", 64'(write_data), 64'hCAFEBABE);
    check("load_ready_back", 64'(mem_ready), 64'd1);

    // Timeout: load rd=9, no response; 15 waiting cycles, then one err pulse.
    exp_q.push_back({1'b1, {ADDR_W{1'b0}}, {DATA_W{1'b0}}});
    drive_instr(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0);
    @(negedge clk);
    idle_inputs();
    low = 0;
    for (int i = 0; i < 40 && !mem_ready; i++) begin
      low++;
      @(negedge clk);
    end
    check("timeout_wait_cycles", 64'(low),       64'd15);
    check("timeout_err",         64'(load_err),  64'd1);
    check("timeout_no_write",    64'(reg_write), 64'd0);
    check("timeout_ready",       64'(mem_ready), 64'd1);
    @(negedge clk);
    check("timeout_err_pulse", 64'(load_err), 64'd0);

    // Link priority over load, then back-to-back ALU write with no wait state.
    exp_q.push_back(wr_ev(5'd31, 32'h40));
    drive_instr(1'b1, 1'b1, 1'b1, 5'd31, 32'h99, 32'h40);
    @(negedge clk);
    check("link_ready", 64'(mem_ready), 64'd1);
    check("link_rd",    64'(write_reg),  64'd31);
    check("link_data",  64'(write_data), 64'h40);
    exp_q.push_back(wr_ev(5'd3, 32'h11));
    drive_instr(1'b1, 1'b0, 1'b0, 5'd3, 32'h11, 32'h0);
    @(negedge clk);
    idle_inputs();
    check("b2b_we",   64'(reg_write),  64'd1);
    check("b2b_rd",   64'(write_reg),  64'd3);
    check("b2b_data", 64'(write_data), 64'h11);
`ifdef WB_FWD_EN
    check("fwd_valid_1", 64'(fwd_valid), 64'd1);
    check("fwd_reg_1",   64'(fwd_reg),   64'd31);
    check("fwd_data_1",  64'(fwd_data),  64'h40);
`endif
    @(negedge clk);
    check("b2b_pulse_end", 64'(reg_write), 64'd0);
`ifdef WB_FWD_EN
    check("fwd_reg_2",  64'(fwd_reg),  64'd3);
    check("fwd_data_2", 64'(fwd_data), 64'h11);
    @(negedge clk);
    check("fwd_valid_drop", 64'(fwd_valid), 64'd0);
`endif

    // Reset during LOAD_WAIT clears outputs without a clock edge; a late
    // response after release must not write.
    drive_instr(1'b1, 1'b1, 1'b0, 5'd12, 32'h0, 32'h0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("midload_waiting", 64'(mem_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_reg",   64'(write_reg),  64'd0);
    check("async_rst_data",  64'(write_data), 64'd0);
    check("async_rst_ready", 64'(mem_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late_rvalid_no_write", 64'(reg_write), 64'd0);
    @(negedge clk);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
